// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit: sequences fetch/decode/execute/memory/writeback
// from the instruction opcode, stalls on mem_ready and counts retired instructions.
module main_control_fsm #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  logic               mem_ready,
    output logic               ALUOp0,
    output logic               ALUOp1,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               pc_source,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               illegal_op,
    output logic [COUNT_W-1:0] instr_count
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        ALU_WB,
        MEM_ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        BRANCH,
        ILLEGAL
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [COUNT_W-1:0] count;
    logic               retire;

    // A store retires only on the edge where memory accepts the write.
    assign retire = (state == ALU_WB) || (state == MEM_WB) || (state == BRANCH) ||
                    ((state == MEM_WR) && mem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            count <= '0;
        end else begin
            state <= next_state;
            if (retire) begin
                count <= count + COUNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            FETCH:    next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                unique case (opcode)
                    OP_R:              next_state = EXEC_R;
                    OP_LOAD, OP_STORE: next_state = MEM_ADDR;
                    OP_BEQ:            next_state = BRANCH;
                    default:           next_state = ILLEGAL;
                endcase
            end
            EXEC_R:   next_state = ALU_WB;
            ALU_WB:   next_state = FETCH;
            MEM_ADDR: next_state = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            MEM_RD:   next_state = mem_ready ? MEM_WB : MEM_RD;
            MEM_WB:   next_state = FETCH;
            MEM_WR:   next_state = mem_ready ? FETCH : MEM_WR;
            BRANCH:   next_state = FETCH;
            ILLEGAL:  next_state = FETCH;
            default:  next_state = FETCH;
        endcase
    end

    always_comb begin
        ALUOp0        = 1'b0;
        ALUOp1        = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        pc_source     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        illegal_op    = 1'b0;
        instr_count   = count;
        unique case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            EXEC_R: begin
                alu_src_a = 2'b10;
                ALUOp1    = 1'b1;
            end
            ALU_WB:   reg_write = 1'b1;
            MEM_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 2'b10;
                ALUOp0        = 1'b1;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
            end
            ILLEGAL:  illegal_op = 1'b1;
            default: ;
        endcase
        // Reset silences every output, even mid-instruction.
        if (rst) begin
            ALUOp0        = 1'b0;
            ALUOp1        = 1'b0;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b00;
            pc_source     = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            illegal_op    = 1'b0;
            instr_count   = '0;
        end
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: instruction-level reference model pushes
// one expected output vector per cycle; a monitor pops and compares each cycle.
module tb_main_control_fsm;

    localparam int CW = 4;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef struct packed {
        logic          a1;
        logic          a0;
        logic [1:0]    sa;
        logic [1:0]    sb;
        logic          psrc;
        logic          pw;
        logic          pwc;
        logic          iod;
        logic          mrd;
        logic          mwr;
        logic          irw;
        logic          m2r;
        logic          rw;
        logic          ill;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_ready = 1'b0;
    logic [6:0]    opcode = 7'd0;
    logic          ALUOp0, ALUOp1, pc_source, pc_write, pc_write_cond, i_or_d;
    logic          mem_read, mem_write, ir_write, mem_to_reg, reg_write, illegal_op;
    logic [1:0]    alu_src_a, alu_src_b;
    logic [CW-1:0] instr_count;

    main_control_fsm #(.COUNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .ALUOp0(ALUOp0), .ALUOp1(ALUOp1), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_source(pc_source), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal_op(illegal_op),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    bit    stim_done = 1'b0;
    int    model_cnt = 0;

    // Expected outputs of each phase of an instruction, straight from the phase table.
    function automatic exp_t ph(string p, bit mr);
        exp_t e = '0;
        case (p)
            "FETCH":    begin e.mrd = 1'b1; e.sb = 2'b01; e.pw = mr; e.irw = mr; end
            "DECODE":   begin e.sa = 2'b01; e.sb = 2'b10; end
            "EXEC_R":   begin e.sa = 2'b10; e.a1 = 1'b1; end
            "ALU_WB":   e.rw = 1'b1;
            "MEM_ADDR": begin e.sa = 2'b10; e.sb = 2'b10; end
            "MEM_RD":   begin e.mrd = 1'b1; e.iod = 1'b1; end
            "MEM_WB":   begin e.rw = 1'b1; e.m2r = 1'b1; end
            "MEM_WR":   begin e.mwr = 1'b1; e.iod = 1'b1; end
            "BRANCH":   begin e.sa = 2'b10; e.a0 = 1'b1; e.pwc = 1'b1; e.psrc = 1'b1; end
            "ILLEGAL":  e.ill = 1'b1;
            default:    e = '0;
        endcase
        return e;
    endfunction

    task automatic step(input bit r, input bit mr, input logic [6:0] op, input string tag,
                        input exp_t e);
        @(negedge clk);
        rst = r;
        mem_ready = mr;
        opcode = op;
        e.cnt = r ? '0 : CW'(model_cnt);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic retire();
        model_cnt = (model_cnt + 1) % (1 << CW);
    endtask

    task automatic reset_cycles(input int n);
        repeat (n) step(1'b1, rbit(), 7'($urandom), "RESET", '0);
        model_cnt = 0;
    endtask

    task automatic fetch_decode(input logic [6:0] op, input int s_fetch);
        repeat (s_fetch) step(1'b0, 1'b0, op, "FETCH_STALL", ph("FETCH", 1'b0));
        step(1'b0, 1'b1, op, "FETCH", ph("FETCH", 1'b1));
        step(1'b0, rbit(), op, "DECODE", ph("DECODE", 1'b0));
    endtask

    task automatic run_instr(input logic [6:0] op, input int s_fetch, input int s_mem);
        fetch_decode(op, s_fetch);
        case (op)
            OP_R: begin
                step(1'b0, rbit(), op, "EXEC_R", ph("EXEC_R", 1'b0));
                step(1'b0, rbit(), op, "ALU_WB", ph("ALU_WB", 1'b0));
                retire();
            end
            OP_LOAD: begin
                step(1'b0, rbit(), op, "MEM_ADDR", ph("MEM_ADDR", 1'b0));
                repeat (s_mem) step(1'b0, 1'b0, op, "MEM_RD_STALL", ph("MEM_RD", 1'b0));
                step(1'b0, 1'b1, op, "MEM_RD", ph("MEM_RD", 1'b1));
                step(1'b0, rbit(), op, "MEM_WB", ph("MEM_WB", 1'b0));
                retire();
            end
            OP_STORE: begin
                step(1'b0, rbit(), op, "MEM_ADDR", ph("MEM_ADDR", 1'b0));
                repeat (s_mem) step(1'b0, 1'b0, op, "MEM_WR_STALL", ph("MEM_WR", 1'b0));
                step(1'b0, 1'b1, op, "MEM_WR", ph("MEM_WR", 1'b1));
                retire();
            end
            OP_BEQ: begin
                step(1'b0, rbit(), op, "BRANCH", ph("BRANCH", 1'b0));
                retire();
            end
            default: step(1'b0, rbit(), op, "ILLEGAL", ph("ILLEGAL", 1'b0));
        endcase
    endtask

    // Store interrupted by reset while the write is still pending.
    task automatic store_reset();
        fetch_decode(OP_STORE, 0);
        step(1'b0, rbit(), OP_STORE, "MEM_ADDR", ph("MEM_ADDR", 1'b0));
        step(1'b0, 1'b0, OP_STORE, "MEM_WR_STALL", ph("MEM_WR", 1'b0));
        reset_cycles(1);
    endtask

    function automatic logic [6:0] rand_op();
        logic [6:0] op;
        case ($urandom_range(0, 4))
            0: op = OP_R;
            1: op = OP_LOAD;
            2: op = OP_STORE;
            3: op = OP_BEQ;
            default: begin
                op = 7'($urandom);
                while (op == OP_R || op == OP_LOAD || op == OP_STORE || op == OP_BEQ)
                    op = 7'($urandom);
            end
        endcase
        return op;
    endfunction

    function automatic int rand_stall();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    initial begin
        reset_cycles(2);
        run_instr(OP_R, 0, 0);
        run_instr(OP_LOAD, 0, 2);
        run_instr(OP_STORE, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(7'b1111111, 0, 0);
        store_reset();
        run_instr(OP_R, 2, 0);
        for (int i = 0; i < 16; i++) run_instr(OP_R, (i == 5) ? 1 : 0, 0);
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 29) == 0) reset_cycles(int'($urandom_range(1, 2)));
            run_instr(rand_op(), rand_stall(), rand_stall());
        end
        stim_done = 1'b1;
    end

    initial begin
        exp_t  e;
        exp_t  act;
        string tag;
        int    cyc = 0;
        forever begin
            @(negedge clk);
            #1;
            if (stim_done && exp_q.size() == 0) break;
            act = '{a1: ALUOp1, a0: ALUOp0, sa: alu_src_a, sb: alu_src_b, psrc: pc_source,
                    pw: pc_write, pwc: pc_write_cond, iod: i_or_d, mrd: mem_read,
                    mwr: mem_write, irw: ir_write, m2r: mem_to_reg, rw: reg_write,
                    ill: illegal_op, cnt: instr_count};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL no_expected cyc%0d: got %h, nothing expected", cyc, act);
            end else begin
                e = exp_q.pop_front();
                tag = tag_q.pop_front();
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s cyc%0d: got %h required %h", tag, cyc, act, e);
                end
            end
            cyc++;
            if (cyc > 50000) begin
                n_fail++;
                $display("FAIL timeout: got %0d cycles required under 50000", cyc);
                break;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
